// File: rtl/synapse_array_pkg.sv
// Shared types, constants and helpers for the time-multiplexed synapse array.
package synapse_array_pkg;

    localparam int unsigned WORD_LENGTH = 16;
    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned CFG_INH_BIT = 8;

    typedef logic signed [WORD_LENGTH-1:0]   fpSignedType;
    typedef logic signed [2*WORD_LENGTH+1:0] fpWideSignedType;

    // One channel's slice of the config chain, in chain order.
    typedef struct packed {
        logic [WORD_LENGTH-1:0] weight;
        logic [WORD_LENGTH-1:0] tau;
        logic [WORD_LENGTH-1:0] general;
    } syn_cfg_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SWEEP  = 2'd1,
        S_FINISH = 2'd2
    } syn_state_t;

    // Clamp a signed value into the range of a signed 'width'-bit word.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                       input int unsigned width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/synapse_channel_alu.sv
// Combinational per-channel update: conductance decay/integration and current term.
module synapse_channel_alu
    import synapse_array_pkg::*;
#(
    parameter int unsigned WORD_W      = WORD_LENGTH,
    parameter int unsigned DECAY_SHIFT = 15,
    parameter int unsigned OUT_SHIFT   = 9
) (
    input  logic        [WORD_W-1:0]   gsyn,
    input  logic        [WORD_W-1:0]   tau,
    input  logic        [WORD_W-1:0]   weight,
    input  logic                       pending,
    input  logic signed [WORD_W-1:0]   e_rev,
    input  logic signed [WORD_W-1:0]   vmem,
    output logic        [WORD_W-1:0]   gsyn_nxt,
    output logic signed [2*WORD_W+1:0] term
);

    localparam int unsigned PROD_W  = 2 * WORD_W;
    localparam int unsigned UPD_W   = PROD_W + 2;
    localparam int unsigned EDIFF_W = WORD_W + 1;
    localparam int unsigned TERM_W  = 2 * WORD_W + 2;

    logic        [PROD_W-1:0]  decay_prod;
    logic        [PROD_W-1:0]  decay;
    logic signed [UPD_W-1:0]   upd;
    logic signed [EDIFF_W-1:0] e_diff;
    logic signed [TERM_W-1:0]  cur_prod;

    // Conductance update: decay, optional weight add, clamp into [0, 2^WORD_W-1].
    always_comb begin
        decay_prod = PROD_W'(gsyn) * PROD_W'(tau);
        decay      = decay_prod >> DECAY_SHIFT;
        upd        = signed'(UPD_W'(gsyn)) - signed'(UPD_W'(decay));
        if (pending) begin
            upd = upd + signed'(UPD_W'(weight));
        end
        if (upd[UPD_W-1]) begin
            gsyn_nxt = '0;
        end else if (|upd[UPD_W-2:WORD_W]) begin
            gsyn_nxt = '1;
        end else begin
            gsyn_nxt = upd[WORD_W-1:0];
        end
        // A residual of 1, or a decay that no longer makes progress, snaps to zero.
        if (!pending && ((gsyn == WORD_W'(1)) || (decay == '0))) begin
            gsyn_nxt = '0;
        end
    end

    // Driving-force current from the pre-update conductance, arithmetic-shifted.
    always_comb begin
        e_diff   = EDIFF_W'(e_rev) - EDIFF_W'(vmem);
        cur_prod = signed'(TERM_W'({1'b0, gsyn})) * TERM_W'(e_diff);
        term     = cur_prod >>> OUT_SHIFT;
    end

endmodule

// File: rtl/synapse_array.sv
// NUM_SYN conductance synapses sharing one ALU, swept once per tick into a dendrite current.
module synapse_array
    import synapse_array_pkg::*;
#(
    parameter int unsigned NUM_SYN     = 8,
    parameter int unsigned WORD_W      = WORD_LENGTH,
    parameter int unsigned DECAY_SHIFT = 15,
    parameter int unsigned OUT_SHIFT   = 9,
    parameter int unsigned ACC_W       = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     spike_valid,
    input  logic                     spike_on_off,
    input  logic [ADDR_W-1:0]        spike_address,
    input  logic signed [WORD_W-1:0] vmem,
    input  logic signed [WORD_W-1:0] e_rev_exc,
    input  logic signed [WORD_W-1:0] e_rev_inh,
    input  logic                     cfg_valid,
    input  logic [WORD_W-1:0]        cfg_data_in,
    output logic [WORD_W-1:0]        cfg_data_out,
    output logic signed [WORD_W-1:0] output_current,
    output logic                     output_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int unsigned IDX_W  = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1;
    localparam int unsigned TERM_W = 2 * WORD_W + 2;

    syn_state_t state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic sweeping, last_idx;
    logic busy_nxt, valid_nxt, overrun_set, start;

    syn_cfg_t          cfg_q   [NUM_SYN];
    logic [WORD_W-1:0] gsyn_q  [NUM_SYN];
    logic [NUM_SYN-1:0] pending_q, spike_hit, consume;

    logic [WORD_W-1:0]        cur_gsyn, cur_tau, cur_weight, alu_gsyn;
    logic                     cur_pending, cur_inh;
    logic signed [WORD_W-1:0] cur_e_rev;
    logic signed [TERM_W-1:0] alu_term;
    logic signed [ACC_W-1:0]  acc_q, acc_nxt;

    assign sweeping     = (state == S_SWEEP);
    assign last_idx     = (idx == IDX_W'(NUM_SYN - 1));
    assign cfg_data_out = WORD_W'(cfg_q[NUM_SYN-1].general);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a tick is only accepted when no sweep is running.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (tick) state_nxt = S_SWEEP;
            S_SWEEP:  if (last_idx) state_nxt = S_FINISH;
            S_FINISH: state_nxt = tick ? S_SWEEP : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered control outputs.
    always_comb begin
        busy_nxt    = (state_nxt == S_SWEEP);
        valid_nxt   = sweeping && last_idx;
        overrun_set = sweeping && tick;
        start       = (state_nxt == S_SWEEP) && !sweeping;
    end

    // Select the channel addressed by idx and mark it for consumption.
    always_comb begin
        cur_gsyn    = '0;
        cur_tau     = '0;
        cur_weight  = '0;
        cur_inh     = 1'b0;
        cur_pending = 1'b0;
        consume     = '0;
        for (int i = 0; i < NUM_SYN; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_gsyn    = gsyn_q[i];
                cur_tau     = WORD_W'(cfg_q[i].tau);
                cur_weight  = WORD_W'(cfg_q[i].weight);
                cur_inh     = cfg_q[i].general[CFG_INH_BIT];
                cur_pending = pending_q[i];
                consume[i]  = sweeping;
            end
        end
        cur_e_rev = cur_inh ? e_rev_inh : e_rev_exc;
    end

    // Spike onset address match, possibly hitting several channels at once.
    always_comb begin
        spike_hit = '0;
        for (int i = 0; i < NUM_SYN; i++) begin
            spike_hit[i] = spike_valid && spike_on_off &&
                           (cfg_q[i].general[ADDR_W-1:0] == spike_address);
        end
    end

    // Saturating accumulation of the current channel's term.
    always_comb begin
        acc_nxt = ACC_W'(sat_signed(64'(acc_q) + 64'(alu_term), ACC_W));
    end

    synapse_channel_alu #(
        .WORD_W      (WORD_W),
        .DECAY_SHIFT (DECAY_SHIFT),
        .OUT_SHIFT   (OUT_SHIFT)
    ) u_alu (
        .gsyn     (cur_gsyn),
        .tau      (cur_tau),
        .weight   (cur_weight),
        .pending  (cur_pending),
        .e_rev    (cur_e_rev),
        .vmem     (vmem),
        .gsyn_nxt (alu_gsyn),
        .term     (alu_term)
    );

    // Config shift chain: input enters channel 0 weight, leaves at last channel general.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SYN; i++) begin
                cfg_q[i] <= '0;
            end
        end else if (cfg_valid) begin
            cfg_q[0].weight <= WORD_LENGTH'(cfg_data_in);
            for (int i = 1; i < NUM_SYN; i++) begin
                cfg_q[i].weight <= cfg_q[i-1].general;
            end
            for (int i = 0; i < NUM_SYN; i++) begin
                cfg_q[i].tau     <= cfg_q[i].weight;
                cfg_q[i].general <= cfg_q[i].tau;
            end
        end
    end

    // Per-channel conductance and pending flags; a same-cycle spike re-arms the flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            for (int i = 0; i < NUM_SYN; i++) begin
                gsyn_q[i] <= '0;
            end
        end else begin
            pending_q <= (pending_q & ~consume) | spike_hit;
            for (int i = 0; i < NUM_SYN; i++) begin
                if (consume[i]) begin
                    gsyn_q[i] <= alu_gsyn;
                end
            end
        end
    end

    // Sweep index, accumulator and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx            <= '0;
            acc_q          <= '0;
            output_current <= '0;
            output_valid   <= 1'b0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            output_valid <= valid_nxt;
            busy         <= busy_nxt;
            if (overrun_set) begin
                overrun <= 1'b1;
            end
            if (start) begin
                idx   <= '0;
                acc_q <= '0;
            end else if (sweeping) begin
                acc_q <= acc_nxt;
                if (!last_idx) begin
                    idx <= idx + IDX_W'(1);
                end
            end
            if (valid_nxt) begin
                output_current <= WORD_W'(sat_signed(64'(acc_nxt), WORD_W));
            end
        end
    end

endmodule
